// File: rtl/adc_decimator.sv
// Boxcar decimator: averages 2^Le A/B ADC samples into one AXI4-Stream word {B16, A16}.
// Result is registered on the edge consuming the frame's last sample; a result meeting a stalled word is dropped and counted.
module adc_decimator #(
   parameter int ADC_DATA_WIDTH = 14,
   parameter int MAX_LOG2_DEC   = 10,
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                             adc_clk,
   input  logic                             adc_rstn,
   input  logic signed [ADC_DATA_WIDTH-1:0] adc_dat_a_i,
   input  logic signed [ADC_DATA_WIDTH-1:0] adc_dat_b_i,
   input  logic                             enable,
   input  logic [3:0]                       dec_log2,
   input  logic                             overrun_clr,
   output logic [31:0]                      m_axis_tdata,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic                             overrun,
   output logic [DROP_CNT_WIDTH-1:0]        drop_cnt
);

   localparam int ACC_W = ADC_DATA_WIDTH + MAX_LOG2_DEC;
   localparam int CNT_W = (MAX_LOG2_DEC > 0) ? MAX_LOG2_DEC : 1;
   localparam int LE_W  = (MAX_LOG2_DEC > 0) ? $clog2(MAX_LOG2_DEC + 1) : 1;
   localparam int PAD_W = 16 - ADC_DATA_WIDTH;

   typedef struct packed {
      logic [15:0] b;
      logic [15:0] a;
   } axis_word_t;

   logic [LE_W-1:0]                 le_eff;
   logic [LE_W-1:0]                 le_q;
   logic signed [ACC_W-1:0]         acc_a;
   logic signed [ACC_W-1:0]         acc_b;
   logic signed [ACC_W-1:0]         sum_a;
   logic signed [ACC_W-1:0]         sum_b;
   logic signed [ADC_DATA_WIDTH-1:0] res_a;
   logic signed [ADC_DATA_WIDTH-1:0] res_b;
   logic [CNT_W-1:0]                cnt;
   logic [CNT_W-1:0]                cnt_last;
   logic [CNT_W:0]                  frame_len;
   logic                            restart;
   logic                            frame_end;
   logic                            load_ok;
   logic                            drop;
   axis_word_t                      res_word;
   axis_word_t                      word_q;

   always_comb begin
      le_eff = LE_W'(dec_log2);
      if (int'(dec_log2) > MAX_LOG2_DEC)
         le_eff = LE_W'(MAX_LOG2_DEC);
   end

   // Current sample is folded into the sum so a frame closes with no gap cycle.
   always_comb begin
      sum_a     = acc_a + ACC_W'(adc_dat_a_i);
      sum_b     = acc_b + ACC_W'(adc_dat_b_i);
      res_a     = ADC_DATA_WIDTH'(sum_a >>> le_q);
      res_b     = ADC_DATA_WIDTH'(sum_b >>> le_q);
      frame_len = (CNT_W+1)'(1) << le_q;
      cnt_last  = CNT_W'(frame_len - (CNT_W+1)'(1));
      restart   = !enable || (le_eff != le_q);
      frame_end = !restart && (cnt == cnt_last);
      load_ok   = !m_axis_tvalid || m_axis_tready;
      drop      = frame_end && !load_ok;
      res_word.a = {{PAD_W{res_a[ADC_DATA_WIDTH-1]}}, res_a};
      res_word.b = {{PAD_W{res_b[ADC_DATA_WIDTH-1]}}, res_b};
   end

   always_ff @(posedge adc_clk) begin
      if (!adc_rstn) begin
         le_q          <= le_eff;
         acc_a         <= '0;
         acc_b         <= '0;
         cnt           <= '0;
         word_q        <= '0;
         m_axis_tvalid <= 1'b0;
         overrun       <= 1'b0;
         drop_cnt      <= '0;
      end else begin
         le_q <= le_eff;

         if (restart || frame_end) begin
            acc_a <= '0;
            acc_b <= '0;
            cnt   <= '0;
         end else begin
            acc_a <= sum_a;
            acc_b <= sum_b;
            cnt   <= cnt + CNT_W'(1);
         end

         if (frame_end && load_ok) begin
            word_q        <= res_word;
            m_axis_tvalid <= 1'b1;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end

         // A drop on the clearing edge still registers as the first drop.
         if (drop) begin
            overrun <= 1'b1;
            if (overrun_clr)
               drop_cnt <= DROP_CNT_WIDTH'(1);
            else if (!(&drop_cnt))
               drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
         end else if (overrun_clr) begin
            overrun  <= 1'b0;
            drop_cnt <= '0;
         end
      end
   end

   assign m_axis_tdata = word_q;

endmodule

// File: tb/tb_adc_decimator.sv
// Self-checking bench for adc_decimator: vector table of frames, scoreboard on accepted words,
// and hand sequences for backpressure drops, exponent change and mid-frame reset.
module tb_adc_decimator;

   logic               adc_clk = 1'b0;
   logic               adc_rstn;
   logic signed [13:0] adc_dat_a_i;
   logic signed [13:0] adc_dat_b_i;
   logic               enable;
   logic [3:0]         dec_log2;
   logic               overrun_clr;
   logic [31:0]        m_axis_tdata;
   logic               m_axis_tvalid;
   logic               m_axis_tready;
   logic               overrun;
   logic [15:0]        drop_cnt;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb_q[$];
   logic [31:0] mon_exp;
   bit          mon_en = 1'b0;

   typedef struct {
      int l;
      int a_first;
      int a_rest;
      int b_first;
      int b_rest;
      int exp_a;
      int exp_b;
   } vec_t;

   vec_t tbl[7];

   always #5 adc_clk = ~adc_clk;

   adc_decimator #(
      .ADC_DATA_WIDTH(14),
      .MAX_LOG2_DEC  (10),
      .DROP_CNT_WIDTH(16)
   ) dut (
      .adc_clk      (adc_clk),
      .adc_rstn     (adc_rstn),
      .adc_dat_a_i  (adc_dat_a_i),
      .adc_dat_b_i  (adc_dat_b_i),
      .enable       (enable),
      .dec_log2     (dec_log2),
      .overrun_clr  (overrun_clr),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .overrun      (overrun),
      .drop_cnt     (drop_cnt)
   );

   function automatic logic [31:0] pack(input int a, input int b);
      return {16'(b), 16'(a)};
   endfunction

   function automatic int floor_div(input int s, input int n);
      int q;
      q = s / n;
      if ((s % n) != 0 && s < 0)
         q = q - 1;
      return q;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge adc_clk);
      #1;
   endtask

   task automatic go_idle(input int l);
      enable   = 1'b0;
      dec_log2 = 4'(l);
      step();
      step();
   endtask

   // Drives one complete frame and queues its expected floor mean.
   task automatic run_frame(input int l, input int a_first, input int a_rest,
                            input int b_first, input int b_rest, input string tag);
      int n, sa, sb, av, bv;
      n  = 1 << ((l > 10) ? 10 : l);
      sa = 0;
      sb = 0;
      for (int i = 0; i < n; i++) begin
         av = (i == 0) ? a_first : a_rest;
         bv = (i == 0) ? b_first : b_rest;
         adc_dat_a_i = 14'(av);
         adc_dat_b_i = 14'(bv);
         enable      = 1'b1;
         dec_log2    = 4'(l);
         sa += av;
         sb += bv;
         step();
         if (i < n - 1)
            chk({tag, "_early_tvalid"}, {31'b0, m_axis_tvalid}, 32'd0);
      end
      sb_q.push_back(pack(floor_div(sa, n), floor_div(sb, n)));
      chk({tag, "_tvalid"}, {31'b0, m_axis_tvalid}, 32'd1);
   endtask

   always @(negedge adc_clk) begin
      if (mon_en && m_axis_tvalid && m_axis_tready) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got 0x%08h, expected no word", m_axis_tdata);
         end else begin
            mon_exp = sb_q.pop_front();
            if (m_axis_tdata !== mon_exp) begin
               errors++;
               $display("FAIL sb_word: got 0x%08h, expected 0x%08h", m_axis_tdata, mon_exp);
            end
         end
      end
   end

   initial begin
      tbl[0] = '{2, 1000, 1000, -1000, -1000, 1000, -1000};
      tbl[1] = '{2, -1, 0, 3, 0, -1, 0};
      tbl[2] = '{3, 8191, 8191, -8192, -8192, 8191, -8192};
      tbl[3] = '{1, -3, 0, 5, 0, -2, 2};
      tbl[4] = '{3, 7, -1, -9, 1, 0, -1};
      tbl[5] = '{0, -5, 0, 17, 0, -5, 17};
      tbl[6] = '{4, 15, 0, -16, 0, 0, -1};

      adc_rstn      = 1'b0;
      enable        = 1'b0;
      dec_log2      = 4'd2;
      adc_dat_a_i   = '0;
      adc_dat_b_i   = '0;
      overrun_clr   = 1'b0;
      m_axis_tready = 1'b1;
      step();
      step();
      chk("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
      chk("rst_tdata", m_axis_tdata, 32'd0);
      chk("rst_overrun", {31'b0, overrun}, 32'd0);
      chk("rst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
      adc_rstn = 1'b1;
      mon_en   = 1'b1;

      for (int r = 0; r < 7; r++) begin
         go_idle(tbl[r].l);
         run_frame(tbl[r].l, tbl[r].a_first, tbl[r].a_rest, tbl[r].b_first, tbl[r].b_rest, "vec");
         chk($sformatf("vec%0d_tdata", r), m_axis_tdata, pack(tbl[r].exp_a, tbl[r].exp_b));
      end
      chk("vec0_const", pack(tbl[0].exp_a, tbl[0].exp_b), 32'hFC18_03E8);

      // L=0 pass-through of a ramp.
      go_idle(0);
      for (int i = 0; i < 10; i++) begin
         adc_dat_a_i = 14'(i);
         adc_dat_b_i = 14'(-i);
         enable      = 1'b1;
         step();
         sb_q.push_back(pack(i, -i));
         chk($sformatf("ramp%0d_tvalid", i), {31'b0, m_axis_tvalid}, 32'd1);
         chk($sformatf("ramp%0d_a", i), {16'b0, m_axis_tdata[15:0]}, {16'b0, 16'(i)});
      end

      // Exponent change mid-frame discards the partial sums.
      go_idle(2);
      adc_dat_a_i = 14'sd500;
      adc_dat_b_i = 14'sd500;
      enable      = 1'b1;
      step();
      step();
      dec_log2    = 4'd3;
      adc_dat_a_i = 14'sd777;
      step();
      run_frame(3, -100, 4, 13, 1, "lechg");
      chk("lechg_tdata", m_axis_tdata, pack(-9, 2));

      // dec_log2 above the maximum clamps to 1024-sample frames.
      go_idle(15);
      run_frame(15, 3, 3, -1, 0, "l15");
      chk("l15_tdata", m_axis_tdata, pack(3, -1));

      // Backpressure: held word, two drops, then recovery.
      go_idle(1);
      chk("sb_drained", sb_q.size(), 32'd0);
      mon_en        = 1'b0;
      m_axis_tready = 1'b0;
      enable        = 1'b1;
      adc_dat_b_i   = '0;
      begin
         int seq[6];
         seq = '{10, 20, 100, 100, -4, -6};
         for (int k = 0; k < 6; k++) begin
            adc_dat_a_i = 14'(seq[k]);
            step();
            if (k >= 1) begin
               chk($sformatf("hold%0d_tvalid", k), {31'b0, m_axis_tvalid}, 32'd1);
               chk($sformatf("hold%0d_tdata", k), m_axis_tdata, pack(15, 0));
            end
            if (k == 3)
               chk("drop1_cnt", {16'b0, drop_cnt}, 32'd1);
         end
      end
      chk("drop_overrun", {31'b0, overrun}, 32'd1);
      chk("drop_cnt2", {16'b0, drop_cnt}, 32'd2);
      m_axis_tready = 1'b1;
      adc_dat_a_i   = 14'sd30;
      step();
      chk("accept_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
      m_axis_tready = 1'b0;
      adc_dat_a_i   = 14'sd50;
      step();
      chk("next_tvalid", {31'b0, m_axis_tvalid}, 32'd1);
      chk("next_tdata", m_axis_tdata, pack(40, 0));
      chk("next_drop_cnt", {16'b0, drop_cnt}, 32'd2);

      enable      = 1'b0;
      overrun_clr = 1'b1;
      step();
      chk("clr_overrun", {31'b0, overrun}, 32'd0);
      chk("clr_drop_cnt", {16'b0, drop_cnt}, 32'd0);
      chk("clr_kept_word", m_axis_tdata, pack(40, 0));
      enable      = 1'b1;
      adc_dat_a_i = 14'sd7;
      step();
      adc_dat_a_i = 14'sd9;
      step();
      chk("clrdrop_overrun", {31'b0, overrun}, 32'd1);
      chk("clrdrop_cnt", {16'b0, drop_cnt}, 32'd1);
      overrun_clr = 1'b0;

      // Reset mid-frame with a pending word and a set overrun flag.
      adc_dat_a_i = 14'sd1000;
      step();
      adc_rstn = 1'b0;
      step();
      chk("mrst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
      chk("mrst_overrun", {31'b0, overrun}, 32'd0);
      chk("mrst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
      chk("mrst_tdata", m_axis_tdata, 32'd0);
      adc_rstn      = 1'b1;
      m_axis_tready = 1'b1;
      mon_en        = 1'b1;
      run_frame(1, 6, 8, -2, -3, "postrst");
      chk("postrst_tdata", m_axis_tdata, pack(7, -3));

      go_idle(0);
      chk("sb_final_empty", sb_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
